// File: rtl/sram_rsp_pkg.sv
// Shared types and helpers for the SRAM responder agent and its byte packer.
package sram_rsp_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  localparam int LAT_CNT_W = 4;

  function automatic int byte_lanes(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/sram_byte_packer.sv
// Byte-serial host load path: packs bytes little-endian into words and
// raises a one-cycle word write strobe for the agent to apply to its array.
module sram_byte_packer
  import sram_rsp_pkg::*;
#(
  parameter int DEPTH    = 1024,
  parameter int WIDTH    = 256,
  parameter int ADDR_BIT = 10
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                start,
  input  logic [ADDR_BIT-1:0] start_addr,
  input  logic                valid,
  input  logic [7:0]          byte_in,
  input  logic                flush,
  input  logic                ready,
  output logic                we,
  output logic [ADDR_BIT-1:0] waddr,
  output logic [WIDTH-1:0]    wdata
);

  localparam int LANES  = byte_lanes(WIDTH);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0]   LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [ADDR_BIT-1:0] LAST_PTR  = ADDR_BIT'(DEPTH - 1);

  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [WIDTH-1:0]    pack_q, pack_d;
  logic [ADDR_BIT-1:0] ptr_q, ptr_d;

  logic             accept;
  logic             flush_go;
  logic             full_go;
  logic [WIDTH-1:0] word;

  // start beats flush beats a byte; a byte arriving alongside either is dropped
  always_comb begin
    accept   = valid & ready & ~start & ~flush;
    flush_go = flush & ready & ~start & (lane_q != '0);
    full_go  = accept & (lane_q == LAST_LANE);

    word = pack_q;
    if (accept) begin
      word[{lane_q, 3'b000} +: 8] = byte_in;
    end

    we    = full_go | flush_go;
    waddr = ptr_q;
    wdata = word;

    lane_d = lane_q;
    pack_d = pack_q;
    ptr_d  = ptr_q;
    if (start) begin
      lane_d = '0;
      pack_d = '0;
      ptr_d  = start_addr;
    end else if (we) begin
      lane_d = '0;
      pack_d = '0;
      ptr_d  = (ptr_q == LAST_PTR) ? '0 : ptr_q + ADDR_BIT'(1);
    end else if (accept) begin
      lane_d = lane_q + LANE_W'(1);
      pack_d = word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      lane_q <= '0;
      pack_q <= '0;
      ptr_q  <= '0;
    end else begin
      lane_q <= lane_d;
      pack_q <= pack_d;
      ptr_q  <= ptr_d;
    end
  end

endmodule

// File: rtl/sram_rsp_agent.sv
// Responder end of the req/ack memory interface with a word-wide array.
// The byte-serial host load port is built only when SRAM_RSP_LOAD_PORT_EN is defined.
module sram_rsp_agent
  import sram_rsp_pkg::*;
#(
  parameter int DEPTH      = 1024,
  parameter int WIDTH      = 256,
  parameter int ADDR_BIT   = 10,
  parameter int RD_LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                req,
  input  logic                r0w1,
  input  logic [ADDR_BIT-1:0] addr,
  input  logic [WIDTH-1:0]    wdata,
  output logic [WIDTH-1:0]    rdata,
  output logic                ack,
  output logic                busy,
  input  logic                ld_start,
  input  logic [ADDR_BIT-1:0] ld_addr,
  input  logic                ld_valid,
  input  logic [7:0]          ld_byte,
  input  logic                ld_flush,
  output logic                ld_ready
);

`ifdef SRAM_RSP_LOAD_PORT_EN
  localparam logic LOAD_EN = 1'b1;
`else
  localparam logic LOAD_EN = 1'b0;
`endif

  localparam logic [ADDR_BIT:0] DEPTH_W = (ADDR_BIT + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  state_e                 state_q, state_d;
  logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_BIT-1:0]    addr_q, addr_d;
  logic                   wr_q, wr_d;
  logic [WIDTH-1:0]       wdata_q, wdata_d;
  logic [WIDTH-1:0]       rdata_q, rdata_d;
  logic                   ack_q, ack_d;
  logic                   busy_q, busy_d;
  logic                   live_q, live_d;
  logic                   gap_q, gap_d;

  logic                   ld_we;
  logic [ADDR_BIT-1:0]    ld_waddr;
  logic [WIDTH-1:0]       ld_wdata;

  logic                   do_cap;
  logic                   mem_we;
  logic [ADDR_BIT-1:0]    mem_waddr;
  logic [WIDTH-1:0]       mem_wdata;

  // Load bytes are taken only while the FSM is idle, and never in the cycle
  // right after a packed word is written.
  assign ld_ready = LOAD_EN & live_q & (state_q == S_IDLE) & ~gap_q;

  sram_byte_packer #(
    .DEPTH    (DEPTH),
    .WIDTH    (WIDTH),
    .ADDR_BIT (ADDR_BIT)
  ) u_packer (
    .clk        (clk),
    .rst_b      (rst_b),
    .start      (LOAD_EN & ld_start),
    .start_addr (ld_addr),
    .valid      (LOAD_EN & ld_valid),
    .byte_in    (ld_byte),
    .flush      (LOAD_EN & ld_flush),
    .ready      (ld_ready),
    .we         (ld_we),
    .waddr      (ld_waddr),
    .wdata      (ld_wdata)
  );

  // Handshake: req/r0w1/addr/wdata are sampled on an edge where the FSM is
  // IDLE or ACK and no load word is being written that edge; req is ignored
  // otherwise. Each accepted request yields exactly one ack pulse, and rdata
  // for a read changes only on the edge that raises ack.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    busy_d  = busy_q;
    live_d  = 1'b1;
    gap_d   = ld_we;
    do_cap  = 1'b0;

    mem_we    = ld_we;
    mem_waddr = ld_waddr;
    mem_wdata = ld_wdata;

    case (state_q)
      S_IDLE: begin
        do_cap = req & ~ld_we;
      end
      S_WAIT: begin
        if (cnt_q <= LAT_CNT_W'(1)) begin
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - LAT_CNT_W'(1);
        end
      end
      S_ACK: begin
        // The access lands on the edge leaving ACK, together with the ack pulse.
        ack_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (wr_q) begin
          mem_we    = 1'b1;
          mem_waddr = addr_q;
          mem_wdata = wdata_q;
        end else if ({1'b0, addr_q} < DEPTH_W) begin
          rdata_d = mem[addr_q];
        end else begin
          rdata_d = '0;
        end
        do_cap = req & ~ld_we;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (do_cap) begin
      state_d = S_WAIT;
      busy_d  = 1'b1;
      addr_d  = addr;
      wr_d    = r0w1;
      wdata_d = wdata;
      cnt_d   = r0w1 ? LAT_CNT_W'(1) : LAT_CNT_W'(RD_LATENCY);
    end

    mem_we = mem_we & rst_b & ({1'b0, mem_waddr} < DEPTH_W);
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      live_q  <= 1'b0;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      live_q  <= live_d;
      gap_q   <= gap_d;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign busy  = busy_q;

endmodule
